// File: rtl/mod53_pkg.sv
// Shared constants and types for the modulo-53 inverse-scaling block.
package mod53_pkg;

  localparam int unsigned MOD   = 53;
  localparam int unsigned W     = 6;
  localparam int unsigned K_INV = 9;  // 6^-1 mod 53

  typedef logic [W-1:0] residue_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod53_dbl_add_step.sv
// One double-and-add step of the bit-serial modular multiplier:
// acc_next = (2*acc [+ a]) mod MOD, with both operands already below MOD,
// so each reduction is a single conditional subtract.
module mod53_dbl_add_step
  import mod53_pkg::*;
#(
  parameter int unsigned MOD = mod53_pkg::MOD,
  parameter int unsigned W   = mod53_pkg::W
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic         add_en,
  output logic [W-1:0] acc_next
);

  localparam logic [W:0] MOD_X = (W+1)'(MOD);

  logic [W:0] dbl;
  logic [W:0] dbl_red;
  logic [W:0] sum;
  logic [W:0] sum_red;

  // Double with one guard bit, reduce, conditionally add, reduce again.
  assign dbl      = {acc, 1'b0};
  assign dbl_red  = (dbl >= MOD_X) ? dbl - MOD_X : dbl;
  assign sum      = dbl_red + (add_en ? {1'b0, a} : '0);
  assign sum_red  = (sum >= MOD_X) ? sum - MOD_X : sum;
  assign acc_next = W'(sum_red);

endmodule

// File: rtl/mod53_inv_scale_seq.sv
// Sequential modulo-53 constant multiplier: out = (a * K_INV) mod MOD,
// one bit of K_INV per cycle (MSB first), valid/ready on both sides.
// Optional macro MOD53_RANGE_CHECK_EN: operands >= MOD are flagged on
// out_err and produce 0; without it they are pre-reduced by one subtract.
module mod53_inv_scale_seq
  import mod53_pkg::*;
#(
  parameter int unsigned MOD   = mod53_pkg::MOD,
  parameter int unsigned W     = mod53_pkg::W,
  parameter int unsigned K_INV = mod53_pkg::K_INV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  localparam int unsigned CW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MOD_V = W'(MOD);
  localparam logic [W-1:0] K_VEC = W'(K_INV);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          out_err_q;
  logic [W-1:0]  a_in;
  logic          err_in;

`ifdef MOD53_RANGE_CHECK_EN
  // Out-of-range operand: compute on zero and flag the result.
  assign err_in = (in_data >= MOD_V);
  assign a_in   = err_in ? '0 : in_data;
`else
  // Out-of-range operand: fold back with one subtract (enough for W=6).
  assign err_in = 1'b0;
  assign a_in   = (in_data >= MOD_V) ? in_data - MOD_V : in_data;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_err   = out_err_q;

  mod53_dbl_add_step #(
    .MOD (MOD),
    .W   (W)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .add_en   (K_VEC[cnt_q]),
    .acc_next (acc_next)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the accept / run / hand-off sequence.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = RUN;
      RUN:     if (cnt_q == '0)     state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Operand capture, serial accumulation and result hold.
  // NOTE: datapath registers are reset as well, so out_data/out_err read
  // 0 after reset and an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      out_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_in;
            err_q <= err_in;
            acc_q <= '0;
            cnt_q <= CW'(W - 1);
          end
        end
        RUN: begin
          acc_q <= acc_next;
          if (cnt_q == '0) begin
            data_q    <= acc_next;
            out_err_q <= err_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mod53_inv_scale_seq.md
Name: mod53_inv_scale_seq

Overview:
Sequential modulo-53 constant multiplier. It undoes the forward residue-scaling LUTs in the mod_53 family by computing out = (a * K_INV) mod 53.
- Bit-serial double-and-add over the W bits of K_INV, one bit per cycle.
- Valid/ready handshake on both input and output.
- Sits downstream of forward-scaled residue channels; restores the unscaled residue before reverse conversion.

Parameters:
MOD, 53, modulus; must satisfy 2^(W-1) < MOD < 2^W.
W, 6, residue and operand width in bits.
K_INV, 9, inverse scaling constant (9 = 6^-1 mod 53); must be < MOD.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept an operand.
in_data  input  W  operand a; nominal range 0..MOD-1.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  W  result (a*K_INV) mod MOD.
out_err  output  1  operand was out of range; driven 0 when the feature is compiled out.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, acc=0, cnt=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a (after range handling), acc=0, cnt=W-1, go to RUN.
  - RUN: in_ready=0. Each cycle: acc = 2*acc mod MOD, then if K_INV[cnt] is set, acc = acc + a mod MOD. Each mod is a single conditional subtract of MOD, since operands are < MOD. If cnt==0, load out_data=acc, set out_valid=1, go to DONE; otherwise cnt--.
  - DONE: out_valid=1; out_data and out_err held stable. On out_valid&out_ready, clear out_valid and go to IDLE.
- Latency: result is visible W cycles after the accept edge (6 for defaults).
- Throughput: one operand per W+2 cycles minimum. No accept in RUN or DONE; in_ready is 0 there.
- Intermediate widths: doubling and addition use W+1 bits; result is always < MOD.
- Reset asserted in RUN or DONE aborts the operation and returns all outputs to reset values next edge; the in-flight result is discarded.
- in_valid deasserted while in_ready=1: no state change.
- out_ready held high in DONE: one-cycle out_valid pulse.

Optional Feature:
Macro MOD53_RANGE_CHECK_EN.
- Defined: in_data >= MOD is captured as a=0 with an err flag. The result is out_data=0, out_err=1, with the same latency and handshake.
- Undefined: in_data >= MOD is pre-reduced by one conditional subtract of MOD (valid for W=6, since 63-53 < 53). out_err is tied 0.
- In-range operands behave identically either way.

Decomposition:
- Package mod53_pkg: MOD, W, K_INV default constants; residue_t (logic [W-1:0]); state enum {IDLE, RUN, DONE}.
- One combinational sub-module, mod53_dbl_add_step: inputs acc, a, bit; output next acc. It implements the double, the conditional add, and the two conditional subtracts. The top holds the FSM, counter and registers.

Test Plan:
- a=6 accepted at edge E0 -> out_valid rises after E6, out_data=1 (6*9=54 mod 53), out_err=0.
- a=1, 0, 52 back-to-back with out_ready=1 -> out_data 9, 0, 44 in order; in_ready low between accepts; each accept W+2 cycles apart.
- a=17 with out_ready=0 for 5 cycles in DONE -> out_data=47 (153 mod 53) stable with out_valid=1 throughout; in_ready=0; completes on the first out_ready=1.
- rst pulsed at the 3rd RUN cycle of a=52 -> next cycle in_ready=1, out_valid=0, out_data=0; a new a=2 then yields 18.
- a=60: macro defined -> out_data=0, out_err=1; macro undefined -> out_data=10 (7*9 mod 53), out_err=0.
- Exhaustive sweep a=0..52 -> out_data matches (a*9) mod 53; forward-scaling by 6 then this block returns a.
